decoder_scan_nto2n: RTL

//  Parametrised registered N-to-2^N one-hot decoder with enable, plus an auto-scan mode.

---
 rtl/decoder_scan_nto2n_if.sv | 17 +
 rtl/decoder_scan_nto2n.sv | 69 ++++++
 2 files changed

// File: rtl/decoder_scan_nto2n_if.sv
// Bus bundle for the N-to-2^N scan decoder: control/select inputs toward the
// decoder and the one-hot, index and wrap outputs back.
interface decoder_scan_nto2n_if #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
);
  logic               EN;
  logic               MODE;
  logic [N-1:0]       A;
  logic [DWELL_W-1:0] DWELL;
  logic [2**N-1:0]    Y;
  logic [N-1:0]       IDX;
  logic               WRAP;

  modport master (output EN, MODE, A, DWELL, input  Y, IDX, WRAP);
  modport slave  (input  EN, MODE, A, DWELL, output Y, IDX, WRAP);
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with enable: direct decode of A, or an
// auto-scan that walks every output line, holding each for DWELL+1 cycles.
module decoder_scan_nto2n #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  decoder_scan_nto2n_if.slave  dec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e             state_q;
  logic [N-1:0]       idx_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               wrap_q;
  logic [2**N-1:0]    y_onehot;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!dec.EN) begin
        // Pause: index and dwell count hold so a later scan resumes in place.
        state_q <= IDLE;
      end else if (!dec.MODE) begin
        state_q <= DIRECT;
        idx_q   <= dec.A;
        cnt_q   <= '0;
      end else begin
        state_q <= SCAN;
        if (state_q == SCAN) begin
          // DWELL is live: lowering it below cnt_q steps on this edge.
          if (cnt_q >= dec.DWELL) begin
            cnt_q  <= '0;
            idx_q  <= idx_q + N'(1);
            wrap_q <= &idx_q;
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end else if (state_q == DIRECT) begin
          cnt_q <= '0;
        end
      end
    end
  end

  // NOTE: default-assign before the conditional write so no latch is inferred.
  always_comb begin
    y_onehot = '0;
    if (state_q != IDLE) y_onehot[idx_q] = 1'b1;
  end

  assign dec.Y    = y_onehot;
  assign dec.IDX  = idx_q;
  assign dec.WRAP = wrap_q;

endmodule
